// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit of the 16-bit core.
// Instruction layout: opcode [15:12], rd [11:8], rs [7:4], rt/imm [3:0].
package pipe_ctrl_pkg;

   localparam int CORE_DATA_W = 16;
   localparam int CORE_REG_AW = 4;
   localparam int CORE_OPC_W  = 4;

   typedef logic [CORE_OPC_W-1:0]  opc_t;
   typedef logic [CORE_REG_AW-1:0] reg_t;

   localparam opc_t OPC_ADD    = 4'h0;
   localparam opc_t OPC_SUB    = 4'h1;
   localparam opc_t OPC_XOR    = 4'h2;
   localparam opc_t OPC_RED    = 4'h3;
   localparam opc_t OPC_SLL    = 4'h4;
   localparam opc_t OPC_SRA    = 4'h5;
   localparam opc_t OPC_ROR    = 4'h6;
   localparam opc_t OPC_PADDSB = 4'h7;
   localparam opc_t OPC_LW     = 4'h8;
   localparam opc_t OPC_SW     = 4'h9;
   localparam opc_t OPC_LLB    = 4'hA;
   localparam opc_t OPC_LHB    = 4'hB;
   localparam opc_t OPC_B      = 4'hC;
   localparam opc_t OPC_BR     = 4'hD;
   localparam opc_t OPC_PCS    = 4'hE;
   localparam opc_t OPC_HLT    = 4'hF;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EXM = 2'b10;
   localparam logic [1:0] FWD_MWB = 2'b01;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
      logic load_byte;
      logic pcs;
      logic hlt;
      opc_t op;
      reg_t dst;
      reg_t src1;
      reg_t src2;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// ID-stage decoder: opcode to control bundle, source-usage flags and branch kind.
module ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [CORE_DATA_W-1:0] instr,
   input  logic                   valid,
   output ctrl_t                  ctrl,
   output logic                   uses_src1,
   output logic                   uses_src2,
   output logic                   branch,
   output logic                   br_reg
);

   opc_t opc;
   reg_t rd, rs, rt;

   assign opc = instr[CORE_DATA_W-1 -: CORE_OPC_W];
   assign rd  = instr[CORE_DATA_W-CORE_OPC_W-1 -: CORE_REG_AW];
   assign rs  = instr[2*CORE_REG_AW-1 -: CORE_REG_AW];
   assign rt  = instr[CORE_REG_AW-1:0];

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      ctrl      = CTRL_BUBBLE;
      uses_src1 = 1'b0;
      uses_src2 = 1'b0;
      branch    = 1'b0;
      br_reg    = 1'b0;
      if (valid) begin
         ctrl.op   = opc;
         ctrl.dst  = rd;
         ctrl.src1 = rs;
         ctrl.src2 = rt;
         case (opc)
            OPC_ADD, OPC_SUB, OPC_XOR, OPC_RED, OPC_PADDSB: begin
               ctrl.reg_write = 1'b1;
               uses_src1      = 1'b1;
               uses_src2      = 1'b1;
            end
            OPC_SLL, OPC_SRA, OPC_ROR: begin
               ctrl.reg_write = 1'b1;
               ctrl.alu_src   = 1'b1;
               uses_src1      = 1'b1;
            end
            OPC_LW: begin
               ctrl.reg_write  = 1'b1;
               ctrl.alu_src    = 1'b1;
               ctrl.mem_read   = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               uses_src1       = 1'b1;
            end
            OPC_SW: begin
               // The store data register lives in the rd field.
               ctrl.alu_src   = 1'b1;
               ctrl.mem_write = 1'b1;
               ctrl.src2      = rd;
               uses_src1      = 1'b1;
               uses_src2      = 1'b1;
            end
            OPC_LLB, OPC_LHB: begin
               ctrl.load_byte = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.src1      = rd;
               uses_src1      = 1'b1;
            end
            OPC_B: begin
               branch = 1'b1;
            end
            OPC_BR: begin
               branch    = 1'b1;
               br_reg    = 1'b1;
               uses_src1 = 1'b1;
            end
            OPC_PCS: begin
               ctrl.pcs       = 1'b1;
               ctrl.reg_write = 1'b1;
            end
            default: begin
               ctrl.hlt = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, EX forwarding, branch flush and HLT sequencing.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DATA_W   = CORE_DATA_W,
   parameter int REG_AW   = CORE_REG_AW,
   parameter int OPC_W    = CORE_OPC_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instr_id,
   input  logic              ifid_valid,
   input  logic              br_taken_id,
   output logic              pc_wen,
   output logic              ifid_wen,
   output logic              ifid_flush,
   output logic              pc_sel_br,
   output logic              br_reg,
   output logic [REG_AW-1:0] id_src1,
   output logic [REG_AW-1:0] id_src2,
   output logic              ex_alu_src,
   output logic              ex_load_byte,
   output logic              ex_pcs,
   output logic [OPC_W-1:0]  ex_op,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              mem_read,
   output logic              mem_write,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic [REG_AW-1:0] wb_dst,
   output logic              halted
);

   ctrl_t dec, idex, exm, mwb;
   logic  uses_src1, uses_src2, dec_branch, dec_br_reg;
   logic  hlt_pend, halted_q;
   logic  stall, br_flush, hlt_now, halting;

   ctrl_decode u_decode (
      .instr     (instr_id),
      .valid     (ifid_valid),
      .ctrl      (dec),
      .uses_src1 (uses_src1),
      .uses_src2 (uses_src2),
      .branch    (dec_branch),
      .br_reg    (dec_br_reg)
   );

   // A register that can be a real hazard/forward source (r0 is excluded when hardwired).
   function automatic logic live(input reg_t r);
      return !ZERO_REG || (r != '0);
   endfunction

   function automatic logic [1:0] fwd_pick(input ctrl_t exm_c, input ctrl_t mwb_c, input reg_t src);
      if (exm_c.reg_write && !exm_c.mem_read && live(exm_c.dst) && exm_c.dst == src)
         return FWD_EXM;
      else if (mwb_c.reg_write && live(mwb_c.dst) && mwb_c.dst == src)
         return FWD_MWB;
      else
         return FWD_RF;
   endfunction

   assign stall = !rst && idex.mem_read && idex.reg_write && live(idex.dst) &&
                  ((idex.dst == dec.src1 && uses_src1) || (idex.dst == dec.src2 && uses_src2));

   assign hlt_now  = !rst && dec.hlt && !stall;
   assign halting  = hlt_pend || hlt_now;
   assign br_flush = !rst && dec_branch && br_taken_id && !stall;

   assign pc_wen     = rst || !(stall || halting);
   assign ifid_wen   = rst || !stall;
   assign ifid_flush = !rst && !stall && (br_flush || halting);
   assign pc_sel_br  = br_flush;
   assign br_reg     = dec_br_reg;
   assign id_src1    = dec.src1;
   assign id_src2    = dec.src2;

   assign fwd_a = rst ? FWD_RF : fwd_pick(exm, mwb, idex.src1);
   assign fwd_b = rst ? FWD_RF : fwd_pick(exm, mwb, idex.src2);

   assign ex_alu_src    = idex.alu_src;
   assign ex_load_byte  = idex.load_byte;
   assign ex_pcs        = idex.pcs;
   assign ex_op         = idex.op;
   assign mem_read      = exm.mem_read;
   assign mem_write     = exm.mem_write;
   assign wb_reg_write  = mwb.reg_write;
   assign wb_mem_to_reg = mwb.mem_to_reg;
   assign wb_dst        = mwb.dst;
   assign halted        = halted_q;

   // NOTE: sequential state uses non-blocking assignments so all stages advance on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         idex     <= CTRL_BUBBLE;
         exm      <= CTRL_BUBBLE;
         mwb      <= CTRL_BUBBLE;
         hlt_pend <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         idex <= stall ? CTRL_BUBBLE : dec;
         exm  <= idex;
         mwb  <= exm;
         if (hlt_now)
            hlt_pend <= 1'b1;
         // HLT in EX/MEM now moves to WB, so the halt becomes visible as it retires.
         if (exm.hlt)
            halted_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs change on negedge, outputs sampled 1 ns later.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, ifid_valid, br_taken_id;
   logic [15:0] instr_id;
   logic        pc_wen, ifid_wen, ifid_flush, pc_sel_br, br_reg;
   logic [3:0]  id_src1, id_src2, ex_op, wb_dst;
   logic        ex_alu_src, ex_load_byte, ex_pcs;
   logic [1:0]  fwd_a, fwd_b;
   logic        mem_read, mem_write, wb_reg_write, wb_mem_to_reg, halted;

   int n_cmp = 0;
   int n_err = 0;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .instr_id(instr_id), .ifid_valid(ifid_valid),
      .br_taken_id(br_taken_id), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
      .ifid_flush(ifid_flush), .pc_sel_br(pc_sel_br), .br_reg(br_reg),
      .id_src1(id_src1), .id_src2(id_src2), .ex_alu_src(ex_alu_src),
      .ex_load_byte(ex_load_byte), .ex_pcs(ex_pcs), .ex_op(ex_op),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_read(mem_read), .mem_write(mem_write),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_dst(wb_dst), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One ID cycle: present an instruction after negedge and let outputs settle.
   task automatic drive(input logic [15:0] i, input logic v, input logic b);
      @(negedge clk);
      instr_id    = i;
      ifid_valid  = v;
      br_taken_id = b;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(16'h0123, 1'b1, 1'b0);
      n_cmp++; if (pc_wen !== 1'b1) begin n_err++; $display("FAIL rst_pc_wen: got %b want 1", pc_wen); end
      n_cmp++; if (ifid_flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", ifid_flush); end
      drive(16'h0123, 1'b1, 1'b0);
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL rst_wb_reg_write: got %b want 0", wb_reg_write); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", halted); end
      n_cmp++; if (ifid_wen !== 1'b1) begin n_err++; $display("FAIL rst_ifid_wen: got %b want 1", ifid_wen); end
      n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_err++; $display("FAIL rst_fwd: got %b/%b want 00/00", fwd_a, fwd_b); end
      @(posedge clk); #1; rst = 1'b0;
      drive(16'h0123, 1'b1, 1'b0);
      drive(16'h0123, 1'b1, 1'b0);
      n_cmp++; if (ex_op !== OPC_ADD || ex_alu_src !== 1'b0) begin n_err++; $display("FAIL first_ex: got op %h alu_src %b want 0/0", ex_op, ex_alu_src); end
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL first_wb_early1: got %b want 0", wb_reg_write); end
      drive(16'h0123, 1'b1, 1'b0);
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL first_wb_early2: got %b want 0", wb_reg_write); end
      drive(16'h0123, 1'b1, 1'b0);
      n_cmp++; if (wb_reg_write !== 1'b1 || wb_dst !== 4'd1) begin n_err++; $display("FAIL first_wb: got we %b dst %0d want 1/1", wb_reg_write, wb_dst); end
      idle(3);
   endtask

   task automatic test_load_use;
      drive(16'h8312, 1'b1, 1'b0);                 // LW R3, R1, 2
      n_cmp++; if (pc_wen !== 1'b1 || id_src1 !== 4'd1) begin n_err++; $display("FAIL lw_id: got pc_wen %b src1 %0d want 1/1", pc_wen, id_src1); end
      drive(16'h0435, 1'b1, 1'b0);                 // ADD R4, R3, R5
      n_cmp++; if (pc_wen !== 1'b0 || ifid_wen !== 1'b0) begin n_err++; $display("FAIL lu_stall: got pc_wen %b ifid_wen %b want 0/0", pc_wen, ifid_wen); end
      n_cmp++; if (id_src1 !== 4'd3 || id_src2 !== 4'd5) begin n_err++; $display("FAIL lu_srcs: got %0d/%0d want 3/5", id_src1, id_src2); end
      drive(16'h0435, 1'b1, 1'b0);                 // held in IF/ID
      n_cmp++; if (pc_wen !== 1'b1 || ifid_wen !== 1'b1) begin n_err++; $display("FAIL lu_one_stall: got pc_wen %b ifid_wen %b want 1/1", pc_wen, ifid_wen); end
      n_cmp++; if (ex_alu_src !== 1'b0 || mem_read !== 1'b1) begin n_err++; $display("FAIL lu_bubble_ex: got alu_src %b mem_read %b want 0/1", ex_alu_src, mem_read); end
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (fwd_a !== FWD_MWB || fwd_b !== FWD_RF) begin n_err++; $display("FAIL lu_fwd: got %b/%b want 01/00", fwd_a, fwd_b); end
      n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL lu_bubble_mem: got %b want 0", mem_read); end
      n_cmp++; if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_dst !== 4'd3) begin n_err++; $display("FAIL lu_wb_lw: got %b %b %0d want 1 1 3", wb_reg_write, wb_mem_to_reg, wb_dst); end
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL lu_wb_bubble: got %b want 0", wb_reg_write); end
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b0 || wb_dst !== 4'd4) begin n_err++; $display("FAIL lu_wb_add: got %b %b %0d want 1 0 4", wb_reg_write, wb_mem_to_reg, wb_dst); end
      idle(3);
   endtask

   task automatic test_back_to_back;
      drive(16'h0211, 1'b1, 1'b0);                 // ADD R2, R1, R1
      drive(16'h1622, 1'b1, 1'b0);                 // SUB R6, R2, R2
      n_cmp++; if (pc_wen !== 1'b1 || ifid_wen !== 1'b1) begin n_err++; $display("FAIL b2b_nostall: got %b/%b want 1/1", pc_wen, ifid_wen); end
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (fwd_a !== FWD_EXM || fwd_b !== FWD_EXM) begin n_err++; $display("FAIL b2b_fwd_exm: got %b/%b want 10/10", fwd_a, fwd_b); end
      n_cmp++; if (ex_op !== OPC_SUB) begin n_err++; $display("FAIL b2b_ex_op: got %h want 1", ex_op); end
      idle(3);
      drive(16'h0211, 1'b1, 1'b0);                 // ADD R2, R1, R1
      drive(16'h0000, 1'b0, 1'b0);
      drive(16'h1622, 1'b1, 1'b0);                 // SUB R6, R2, R2
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (fwd_a !== FWD_MWB || fwd_b !== FWD_MWB) begin n_err++; $display("FAIL b2b_fwd_mwb: got %b/%b want 01/01", fwd_a, fwd_b); end
      idle(3);
      drive(16'h0211, 1'b1, 1'b0);                 // ADD R2, R1, R1
      drive(16'h0233, 1'b1, 1'b0);                 // ADD R2, R3, R3
      drive(16'h1622, 1'b1, 1'b0);                 // SUB R6, R2, R2
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (fwd_a !== FWD_EXM || fwd_b !== FWD_EXM) begin n_err++; $display("FAIL b2b_fwd_prio: got %b/%b want 10/10", fwd_a, fwd_b); end
      idle(3);
      drive(16'h0011, 1'b1, 1'b0);                 // ADD R0, R1, R1
      drive(16'h1600, 1'b1, 1'b0);                 // SUB R6, R0, R0
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (fwd_a !== FWD_RF || fwd_b !== FWD_RF) begin n_err++; $display("FAIL b2b_fwd_r0: got %b/%b want 00/00", fwd_a, fwd_b); end
      idle(3);
   endtask

   task automatic test_branch;
      drive(16'hC004, 1'b1, 1'b1);                 // B taken
      n_cmp++; if (pc_sel_br !== 1'b1 || ifid_flush !== 1'b1) begin n_err++; $display("FAIL br_taken: got sel %b flush %b want 1/1", pc_sel_br, ifid_flush); end
      n_cmp++; if (br_reg !== 1'b0 || pc_wen !== 1'b1) begin n_err++; $display("FAIL br_taken_misc: got br_reg %b pc_wen %b want 0/1", br_reg, pc_wen); end
      drive(16'h0789, 1'b0, 1'b0);                 // squashed ADD R7
      n_cmp++; if (pc_sel_br !== 1'b0 || ifid_flush !== 1'b0) begin n_err++; $display("FAIL br_one_cycle: got sel %b flush %b want 0/0", pc_sel_br, ifid_flush); end
      idle(3);
      n_cmp++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL br_squash_wb: got %b want 0", wb_reg_write); end
      drive(16'hC004, 1'b1, 1'b0);                 // B not taken
      n_cmp++; if (pc_sel_br !== 1'b0 || ifid_flush !== 1'b0) begin n_err++; $display("FAIL br_not_taken: got sel %b flush %b want 0/0", pc_sel_br, ifid_flush); end
      idle(3);
   endtask

   task automatic test_stall_branch;
      drive(16'h8210, 1'b1, 1'b0);                 // LW R2, R1, 0
      drive(16'hD020, 1'b1, 1'b1);                 // BR R2, taken
      n_cmp++; if (pc_wen !== 1'b0 || ifid_wen !== 1'b0) begin n_err++; $display("FAIL sb_stall: got %b/%b want 0/0", pc_wen, ifid_wen); end
      n_cmp++; if (pc_sel_br !== 1'b0 || ifid_flush !== 1'b0) begin n_err++; $display("FAIL sb_hold_branch: got sel %b flush %b want 0/0", pc_sel_br, ifid_flush); end
      drive(16'hD020, 1'b1, 1'b1);
      n_cmp++; if (pc_sel_br !== 1'b1 || br_reg !== 1'b1 || ifid_flush !== 1'b1) begin n_err++; $display("FAIL sb_resolve: got sel %b br_reg %b flush %b want 1 1 1", pc_sel_br, br_reg, ifid_flush); end
      idle(3);
   endtask

   task automatic test_hlt;
      drive(16'hF000, 1'b0, 1'b0);                 // HLT arriving as bubble
      n_cmp++; if (pc_wen !== 1'b1 || ifid_flush !== 1'b0) begin n_err++; $display("FAIL hlt_bubble: got pc_wen %b flush %b want 1/0", pc_wen, ifid_flush); end
      idle(3);
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL hlt_bubble_halted: got %b want 0", halted); end
      drive(16'h0123, 1'b1, 1'b0);                 // ADD R1, R2, R3
      drive(16'hF000, 1'b1, 1'b0);                 // HLT
      n_cmp++; if (pc_wen !== 1'b0 || ifid_flush !== 1'b1) begin n_err++; $display("FAIL hlt_id: got pc_wen %b flush %b want 0/1", pc_wen, ifid_flush); end
      drive(16'h0567, 1'b0, 1'b0);                 // trailing ADD, flushed
      n_cmp++; if (pc_wen !== 1'b0 || ifid_flush !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL hlt_pend: got %b %b %b want 0 1 0", pc_wen, ifid_flush, halted); end
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (wb_reg_write !== 1'b1 || wb_dst !== 4'd1 || halted !== 1'b0) begin n_err++; $display("FAIL hlt_older_wb: got %b %0d halted %b want 1 1 0", wb_reg_write, wb_dst, halted); end
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (halted !== 1'b1 || wb_reg_write !== 1'b0) begin n_err++; $display("FAIL hlt_retire: got halted %b we %b want 1/0", halted, wb_reg_write); end
      for (int k = 0; k < 3; k++) begin
         drive(16'h0000, 1'b0, 1'b0);
         n_cmp++; if (halted !== 1'b1 || pc_wen !== 1'b0 || wb_reg_write !== 1'b0) begin n_err++; $display("FAIL hlt_sticky%0d: got %b %b %b want 1 0 0", k, halted, pc_wen, wb_reg_write); end
      end
      rst = 1'b1; #1;
      n_cmp++; if (pc_wen !== 1'b1 || ifid_flush !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL hlt_rst_comb: got %b %b %b want 1 0 1", pc_wen, ifid_flush, halted); end
      @(posedge clk); #1; rst = 1'b0;
      drive(16'h0000, 1'b0, 1'b0);
      n_cmp++; if (halted !== 1'b0 || pc_wen !== 1'b1 || ifid_flush !== 1'b0) begin n_err++; $display("FAIL hlt_after_rst: got %b %b %b want 0 1 0", halted, pc_wen, ifid_flush); end
   endtask

   initial begin
      rst         = 1'b1;
      instr_id    = 16'h0000;
      ifid_valid  = 1'b0;
      br_taken_id = 1'b0;
      test_reset;
      test_load_use;
      test_back_to_back;
      test_branch;
      test_stall_branch;
      test_hlt;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
